// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Round-robin front end that lets NUM_CH clients share one memory controller,
// with one transaction in flight at a time. A granted request is launched with
// a one-cycle mc_ready strobe and its command fields are held stable until the
// controller answers with mc_valid. The arbiter then returns a done pulse, plus
// err when applicable, to the granted client. Unsupported commands (00/11) are
// answered with done+err without touching the controller. When TIMEOUT_CYC is
// non-zero, a controller that never answers also ends in done+err.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   ch_req[i]         level request from client i, held until ch_ack[i]
//   ch_cmd/addr/wdata flattened per-client fields (client i in slice i)
//   ch_ack/done/err   one-hot, one-cycle pulses towards the granted client
//   ch_rdata          read data, meaningful while ch_done is high, else 0
//   busy              high whenever the FSM is not idle
//   mc_cmd/addr/wr_dq command fields towards the controller
//   mc_ready          one-cycle launch strobe towards the controller
//   mc_valid/rd_dq    completion strobe and read data from the controller
// All outputs are registered.
module mem_req_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [2*NUM_CH-1:0]      ch_cmd,
  input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
  input  logic [DATA_W*NUM_CH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [NUM_CH-1:0]        ch_err,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     busy,
  output logic [1:0]               mc_cmd,
  output logic [ADDR_W-1:0]        mc_addr,
  output logic [DATA_W-1:0]        mc_wr_dq,
  output logic                     mc_ready,
  input  logic                     mc_valid,
  input  logic [DATA_W-1:0]        mc_rd_dq
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // A zero TIMEOUT_CYC disables the timeout; keep a 1-bit counter so widths stay legal.
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [1:0]       CMD_WRITE = 2'b10;
  localparam logic [1:0]       CMD_READ  = 2'b01;
  localparam logic [PTR_W:0]   NUM_CH_L  = (PTR_W + 1)'(NUM_CH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LIMIT  = CNT_W'(TIMEOUT_CYC - 1);
  localparam bit               TO_EN     = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  function automatic logic cmd_ok(input logic [1:0] c);
    cmd_ok = (c == CMD_WRITE) || (c == CMD_READ);
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input logic [PTR_W-1:0] i);
    onehot    = {NUM_CH{1'b0}};
    onehot[i] = 1'b1;
  endfunction

  // Unpacked views of the flattened client buses.
  logic [1:0]        cmd_a   [NUM_CH];
  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [DATA_W-1:0] wdata_a [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign cmd_a[g]   = ch_cmd[2*g +: 2];
    assign addr_a[g]  = ch_addr[ADDR_W*g +: ADDR_W];
    assign wdata_a[g] = ch_wdata[DATA_W*g +: DATA_W];
  end

  state_t            state_r, state_s;
  logic [PTR_W-1:0]  rr_ptr_r, rr_ptr_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s, cnt_inc_s;
  logic [PTR_W-1:0]  grant_r, grant_s;
  logic [1:0]        cmd_r, cmd_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic              err_r, err_s;
  logic [DATA_W-1:0] rdata_r, rdata_s;
  logic              timeout_s;

  logic              req_any_s;
  logic [PTR_W-1:0]  req_idx_s;
  logic [PTR_W:0]    arb_sum_s;
  logic [PTR_W-1:0]  arb_idx_s;

  logic [NUM_CH-1:0] ch_ack_r, ch_ack_s;
  logic [NUM_CH-1:0] ch_done_r, ch_done_s;
  logic [NUM_CH-1:0] ch_err_r, ch_err_s;
  logic [DATA_W-1:0] ch_rdata_r, ch_rdata_s;
  logic              busy_r, busy_s;
  logic [1:0]        mc_cmd_r, mc_cmd_s;
  logic [ADDR_W-1:0] mc_addr_r, mc_addr_s;
  logic [DATA_W-1:0] mc_wr_dq_r, mc_wr_dq_s;
  logic              mc_ready_r, mc_ready_s;

  // Round-robin search: scanning offsets downward lets the smallest offset from rr_ptr win.
  always_comb begin
    req_any_s = 1'b0;
    req_idx_s = {PTR_W{1'b0}};
    arb_sum_s = {(PTR_W + 1){1'b0}};
    arb_idx_s = {PTR_W{1'b0}};
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      arb_sum_s = {1'b0, rr_ptr_r} + (PTR_W + 1)'(k);
      arb_idx_s = (arb_sum_s >= NUM_CH_L) ? PTR_W'(arb_sum_s - NUM_CH_L) : PTR_W'(arb_sum_s);
      if (ch_req[arb_idx_s]) begin
        req_any_s = 1'b1;
        req_idx_s = arb_idx_s;
      end else begin
        req_any_s = req_any_s;
      end
    end
  end

  // Saturating wait counter and timeout detect; the check uses the value the counter is about to take.
  always_comb begin
    cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
    timeout_s = TO_EN && (cnt_inc_s >= TO_LIMIT);
  end

  // Next-state logic plus next values of every registered output.
  always_comb begin
    state_s  = state_r;
    rr_ptr_s = rr_ptr_r;
    cnt_s    = cnt_r;
    grant_s  = grant_r;
    cmd_s    = cmd_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    err_s    = err_r;
    rdata_s  = rdata_r;

    case (state_r)
      S_IDLE: begin
        if (req_any_s) begin
          grant_s = req_idx_s;
          cmd_s   = cmd_a[req_idx_s];
          addr_s  = addr_a[req_idx_s];
          wdata_s = wdata_a[req_idx_s];
          err_s   = 1'b0;
          rdata_s = {DATA_W{1'b0}};
          state_s = S_ISSUE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (cmd_ok(cmd_r)) begin
          state_s = S_WAIT;
        end else begin
          err_s   = 1'b1;
          rdata_s = {DATA_W{1'b0}};
          state_s = S_DONE;
        end
      end
      S_WAIT: begin
        cnt_s = cnt_inc_s;
        // mc_valid is tested first so a completion coinciding with the timeout is not an error.
        if (mc_valid) begin
          err_s   = 1'b0;
          rdata_s = (cmd_r == CMD_READ) ? mc_rd_dq : {DATA_W{1'b0}};
          state_s = S_DONE;
        end else if (timeout_s) begin
          err_s   = 1'b1;
          rdata_s = {DATA_W{1'b0}};
          state_s = S_DONE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_DONE: begin
        rr_ptr_s = (grant_r == PTR_LAST) ? {PTR_W{1'b0}} : grant_r + PTR_W'(1);
        cnt_s    = {CNT_W{1'b0}};
        state_s  = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // Outputs are registered from the state being entered, so they line up with that state.
    busy_s     = (state_s != S_IDLE);
    ch_ack_s   = (state_s == S_ISSUE) ? onehot(grant_s) : {NUM_CH{1'b0}};
    mc_ready_s = (state_s == S_ISSUE) && cmd_ok(cmd_s);
    mc_cmd_s   = ((state_s == S_ISSUE) || (state_s == S_WAIT)) ? cmd_s : 2'b00;
    mc_addr_s  = ((state_s == S_ISSUE) || (state_s == S_WAIT)) ? addr_s : {ADDR_W{1'b0}};
    mc_wr_dq_s = ((state_s == S_ISSUE) || (state_s == S_WAIT)) ? wdata_s : {DATA_W{1'b0}};
    ch_done_s  = (state_s == S_DONE) ? onehot(grant_s) : {NUM_CH{1'b0}};
    ch_err_s   = ((state_s == S_DONE) && err_s) ? onehot(grant_s) : {NUM_CH{1'b0}};
    ch_rdata_s = (state_s == S_DONE) ? rdata_s : {DATA_W{1'b0}};
  end

  // State, transaction latches and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      rr_ptr_r   <= {PTR_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      grant_r    <= {PTR_W{1'b0}};
      cmd_r      <= 2'b00;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      err_r      <= 1'b0;
      rdata_r    <= {DATA_W{1'b0}};
      ch_ack_r   <= {NUM_CH{1'b0}};
      ch_done_r  <= {NUM_CH{1'b0}};
      ch_err_r   <= {NUM_CH{1'b0}};
      ch_rdata_r <= {DATA_W{1'b0}};
      busy_r     <= 1'b0;
      mc_cmd_r   <= 2'b00;
      mc_addr_r  <= {ADDR_W{1'b0}};
      mc_wr_dq_r <= {DATA_W{1'b0}};
      mc_ready_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      rr_ptr_r   <= rr_ptr_s;
      cnt_r      <= cnt_s;
      grant_r    <= grant_s;
      cmd_r      <= cmd_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
      err_r      <= err_s;
      rdata_r    <= rdata_s;
      ch_ack_r   <= ch_ack_s;
      ch_done_r  <= ch_done_s;
      ch_err_r   <= ch_err_s;
      ch_rdata_r <= ch_rdata_s;
      busy_r     <= busy_s;
      mc_cmd_r   <= mc_cmd_s;
      mc_addr_r  <= mc_addr_s;
      mc_wr_dq_r <= mc_wr_dq_s;
      mc_ready_r <= mc_ready_s;
    end
  end

  assign ch_ack   = ch_ack_r;
  assign ch_done  = ch_done_r;
  assign ch_err   = ch_err_r;
  assign ch_rdata = ch_rdata_r;
  assign busy     = busy_r;
  assign mc_cmd   = mc_cmd_r;
  assign mc_addr  = mc_addr_r;
  assign mc_wr_dq = mc_wr_dq_r;
  assign mc_ready = mc_ready_r;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Testbench for mem_req_arbiter (NUM_CH=4, ADDR_W=25, DATA_W=16, TIMEOUT_CYC=8).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 time unit
// after the following rising edge.
module tb_mem_req_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 25;
  localparam int DW  = 16;
  localparam int TO  = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      ch_req = 4'b0;
  logic [7:0]      ch_cmd = 8'h00;
  logic [99:0]     ch_addr = 100'b0;
  logic [63:0]     ch_wdata = 64'b0;
  logic [3:0]      ch_ack, ch_done, ch_err;
  logic [15:0]     ch_rdata;
  logic            busy;
  logic [1:0]      mc_cmd;
  logic [24:0]     mc_addr;
  logic [15:0]     mc_wr_dq;
  logic            mc_ready;
  logic            mc_valid = 1'b0;
  logic [15:0]     mc_rd_dq = 16'h0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_req(ch_req), .ch_cmd(ch_cmd), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_ack(ch_ack), .ch_done(ch_done), .ch_err(ch_err), .ch_rdata(ch_rdata),
    .busy(busy), .mc_cmd(mc_cmd), .mc_addr(mc_addr), .mc_wr_dq(mc_wr_dq),
    .mc_ready(mc_ready), .mc_valid(mc_valid), .mc_rd_dq(mc_rd_dq)
  );

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  cmd;
    logic [24:0] a2;
    logic [15:0] w2;
    logic        mv;
    logic [15:0] rd;
    logic [72:0] exp;
  } row_t;

  row_t tbl [10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [72:0] outs();
    return {ch_ack, ch_done, ch_err, ch_rdata, busy, mc_cmd, mc_addr, mc_wr_dq, mc_ready};
  endfunction

  function automatic logic [72:0] mk(input logic [3:0] ak, input logic [3:0] dn,
                                     input logic [3:0] er, input logic [15:0] rdt,
                                     input logic bz, input logic [1:0] mcm,
                                     input logic [24:0] ma, input logic [15:0] mw,
                                     input logic rdy);
    return {ak, dn, er, rdt, bz, mcm, ma, mw, rdy};
  endfunction

  task automatic set_row(input int i, input logic [3:0] rq, input logic [7:0] cm,
                         input logic [24:0] a, input logic [15:0] w, input logic mv,
                         input logic [15:0] rd, input logic [72:0] e);
    tbl[i].req = rq; tbl[i].cmd = cm; tbl[i].a2 = a; tbl[i].w2 = w;
    tbl[i].mv = mv; tbl[i].rd = rd; tbl[i].exp = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for an ack; expects exactly the one-hot bit of ch and the given launch fields.
  task automatic wait_ack(input int ch, input logic rdy, input logic [1:0] cm, input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      tick();
      if (ch_ack != 4'b0) seen = 1'b1;
    end
    chk({nm, "_ack"}, 128'({ch_ack, mc_ready, mc_cmd}), 128'({4'(1 << ch), rdy, cm}));
  endtask

  // From the ack cycle: mc_valid is driven in the lat-th cycle after it; ends in the DONE cycle.
  task automatic complete(input int lat, input logic [15:0] rd);
    tick();
    for (int k = 1; k < lat; k++) tick();
    mc_valid = 1'b1;
    mc_rd_dq = rd;
    tick();
    mc_valid = 1'b0;
    mc_rd_dq = 16'h0;
  endtask

  task automatic expect_done(input int ch, input logic er, input logic [15:0] rd, input string nm);
    chk({nm, "_done"}, 128'({ch_done, ch_err, ch_rdata, busy}),
        128'({4'(1 << ch), (er ? 4'(1 << ch) : 4'b0), rd, 1'b1}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit early;

    // ch2 write then read of the same address; cmd/addr change after capture must not matter.
    set_row(0, 4'b0100, 8'h20, 25'h0000123, 16'hBEEF, 1'b0, 16'h0000,
            mk(4'b0100, 4'b0, 4'b0, 16'h0, 1'b1, 2'b10, 25'h123, 16'hBEEF, 1'b1));
    set_row(1, 4'b0000, 8'h00, 25'h0, 16'h0, 1'b0, 16'h0000,
            mk(4'b0, 4'b0, 4'b0, 16'h0, 1'b1, 2'b10, 25'h123, 16'hBEEF, 1'b0));
    set_row(2, 4'b0000, 8'h00, 25'h0, 16'h0, 1'b0, 16'h0000,
            mk(4'b0, 4'b0, 4'b0, 16'h0, 1'b1, 2'b10, 25'h123, 16'hBEEF, 1'b0));
    set_row(3, 4'b0000, 8'h00, 25'h0, 16'h0, 1'b1, 16'h1234,
            mk(4'b0, 4'b0100, 4'b0, 16'h0, 1'b1, 2'b00, 25'h0, 16'h0, 1'b0));
    set_row(4, 4'b0000, 8'h00, 25'h0, 16'h0, 1'b0, 16'h0000,
            mk(4'b0, 4'b0, 4'b0, 16'h0, 1'b0, 2'b00, 25'h0, 16'h0, 1'b0));
    set_row(5, 4'b0100, 8'h10, 25'h0000123, 16'h0, 1'b1, 16'h7777,
            mk(4'b0100, 4'b0, 4'b0, 16'h0, 1'b1, 2'b01, 25'h123, 16'h0, 1'b1));
    set_row(6, 4'b0000, 8'h00, 25'h0, 16'h0, 1'b1, 16'hAAAA,
            mk(4'b0, 4'b0, 4'b0, 16'h0, 1'b1, 2'b01, 25'h123, 16'h0, 1'b0));
    set_row(7, 4'b0000, 8'h00, 25'h0, 16'h0, 1'b1, 16'hBEEF,
            mk(4'b0, 4'b0100, 4'b0, 16'hBEEF, 1'b1, 2'b00, 25'h0, 16'h0, 1'b0));
    set_row(8, 4'b0000, 8'h00, 25'h0, 16'h0, 1'b1, 16'h1111,
            mk(4'b0, 4'b0, 4'b0, 16'h0, 1'b0, 2'b00, 25'h0, 16'h0, 1'b0));
    set_row(9, 4'b0000, 8'h00, 25'h0, 16'h0, 1'b0, 16'h0000,
            mk(4'b0, 4'b0, 4'b0, 16'h0, 1'b0, 2'b00, 25'h0, 16'h0, 1'b0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 128'(outs()), 128'(0));
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 128'(outs()), 128'(0));

    // Table-driven write/read on ch2
    for (int i = 0; i < 10; i++) begin
      ch_req   = tbl[i].req;
      ch_cmd   = tbl[i].cmd;
      ch_addr  = 100'(tbl[i].a2) << 50;
      ch_wdata = 64'(tbl[i].w2) << 32;
      mc_valid = tbl[i].mv;
      mc_rd_dq = tbl[i].rd;
      tick();
      chk($sformatf("t1_row%0d", i), 128'(outs()), 128'(tbl[i].exp));
    end
    mc_valid = 1'b0;
    mc_rd_dq = 16'h0;

    // rr_ptr is now 3: ch1 and ch3 requesting -> ch3 first, then ch1
    ch_req   = 4'b1010;
    ch_cmd   = 8'h84;
    ch_addr  = (100'(25'h0000AAA) << 75) | (100'(25'h0000111) << 25);
    ch_wdata = 64'h1234_0000_5555_0000;
    wait_ack(3, 1'b1, 2'b10, "t3_first");
    chk("t3_first_addr", 128'({mc_addr, mc_wr_dq}), 128'({25'h0000AAA, 16'h1234}));
    ch_req = 4'b0010;
    complete(2, 16'hFFFF);
    expect_done(3, 1'b0, 16'h0000, "t3_first");
    wait_ack(1, 1'b1, 2'b01, "t3_second");
    chk("t3_second_addr", 128'(mc_addr), 128'(25'h0000111));
    ch_req = 4'b0000;
    complete(1, 16'h5A5A);
    expect_done(1, 1'b0, 16'h5A5A, "t3_second");

    // Bad command 11 on ch1: ack without mc_ready, then done+err with zero data
    ch_req = 4'b0010;
    ch_cmd = 8'h0C;
    wait_ack(1, 1'b0, 2'b11, "t4");
    ch_req = 4'b0000;
    tick();
    expect_done(1, 1'b1, 16'h0000, "t4");
    tick();
    chk("t4_idle_busy", 128'(busy), 128'(0));

    // Timeout on ch0: err pulse in the 8th cycle after mc_ready, then busy drops
    ch_req = 4'b0001;
    ch_cmd = 8'h01;
    wait_ack(0, 1'b1, 2'b01, "t5");
    ch_req = 4'b0000;
    early = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick();
      if (ch_done != 4'b0 || !busy || mc_cmd != 2'b01) early = 1'b1;
    end
    chk("t5_wait_stable", 128'(early), 128'(0));
    tick();
    expect_done(0, 1'b1, 16'h0000, "t5_timeout");
    tick();
    chk("t5_idle_busy", 128'(busy), 128'(0));

    // mc_valid in the same cycle as the timeout: completion wins, no err
    ch_req = 4'b0010;
    ch_cmd = 8'h04;
    wait_ack(1, 1'b1, 2'b01, "t5_tie");
    ch_req = 4'b0000;
    complete(7, 16'hC0DE);
    expect_done(1, 1'b0, 16'hC0DE, "t5_tie");

    // Reset during WAIT: outputs drop at once, no done afterwards
    ch_req = 4'b0100;
    ch_cmd = 8'h10;
    wait_ack(2, 1'b1, 2'b01, "t6_pre");
    ch_req = 4'b0000;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset", 128'(outs()), 128'(0));
    mc_valid = 1'b1;
    mc_rd_dq = 16'hDEAD;
    tick();
    tick();
    mc_valid = 1'b0;
    mc_rd_dq = 16'h0;
    rst_n = 1'b1;
    tick();
    tick();
    chk("t6_quiet_after_reset", 128'(outs()), 128'(0));

    // All four requesting after reset: grants 0,1,2,3 then 0 again
    ch_req = 4'b1111;
    ch_cmd = 8'h55;
    for (int i = 0; i < 4; i++) ch_addr[25*i +: 25] = 25'(32'h100 + i);
    for (int g = 0; g < 5; g++) begin
      wait_ack(g % 4, 1'b1, 2'b01, $sformatf("t2_g%0d", g));
      chk($sformatf("t2_g%0d_addr", g), 128'(mc_addr), 128'(32'h100 + (g % 4)));
      if (g == 4) ch_req = 4'b0000;
      complete(1, 16'(16'hA000 + g));
      expect_done(g % 4, 1'b0, 16'(16'hA000 + g), $sformatf("t2_g%0d", g));
    end
    tick();
    chk("t2_final_idle", 128'(outs()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
